// File: rtl/usb_buf_pkg.sv
// Shared definitions for the USB endpoint buffer clients (OUT-side reader,
// IN-side writer): buffer geometry, reader state encoding, stream beat.
package usb_buf_pkg;

    localparam int USB_BUF_ADDR_W  = 9;
    localparam int USB_BUF_LEN_W   = 10;
    localparam int USB_BUF_MAX_LEN = 512;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_DATA,
        ST_READ,
        ST_DRAIN
    } rd_state_t;

    // One byte of the output stream plus its end-of-packet marker.
    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } stream_beat_t;

endpackage

// File: rtl/usb_skid_fifo.sv
// Two-entry FIFO with the head entry held in a register that drives the
// stream outputs directly. Occupancy is exported so the producer can throttle
// its reads; the producer guarantees it never pushes into a full FIFO
// unless a pop happens in the same cycle.
module usb_skid_fifo
    import usb_buf_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  stream_beat_t i_din,
    input  logic         i_ready,
    output stream_beat_t o_dout,
    output logic         o_valid,
    output logic         o_pop,
    output logic [1:0]   o_count
);

    stream_beat_t r_head;
    stream_beat_t r_tail;
    logic [1:0]   r_count;
    logic         w_pop;

    assign w_pop   = i_ready && (r_count != 2'd0);
    assign o_dout  = r_head;
    assign o_valid = (r_count != 2'd0);
    assign o_pop   = w_pop;
    assign o_count = r_count;

    // Head/tail storage and occupancy; the head always holds the oldest byte.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= i_din;
                    end else begin
                        r_tail <= i_din;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= i_din;
                    end else begin
                        r_head <= i_din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/usb_buf_out_reader.sv
// OUT endpoint buffer reader: arms the buffer, waits for a packet, fetches it
// through the one-cycle-latency read port and streams it out with a last flag.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | not armed; waits for enable
// ARM        | buf_out_arm held high until the core acknowledges
// WAIT_DATA  | armed; waits for hasdata, latches clipped length
// READ       | issuing buffer reads, throttled by FIFO room
// DRAIN      | all reads issued; waits for the last byte to be accepted
module usb_buf_out_reader
    import usb_buf_pkg::*;
#(
    parameter int ADDR_W  = USB_BUF_ADDR_W,
    parameter int LEN_W   = USB_BUF_LEN_W,
    parameter int MAX_LEN = USB_BUF_MAX_LEN
) (
    input  logic              clk_125,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] buf_out_addr,
    input  logic [7:0]        buf_out_q,
    input  logic [LEN_W-1:0]  buf_out_len,
    input  logic              buf_out_hasdata,
    output logic              buf_out_arm,
    input  logic              buf_out_arm_ack,
    output logic [7:0]        m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic              zlp_pulse,
    output logic              err_len,
    output logic [15:0]       stat_pkt_count
);

    localparam logic [LEN_W-1:0] LP_MAX_LEN = LEN_W'(MAX_LEN);

    rd_state_t         r_state;
    logic              r_arm;
    logic              r_zlp;
    logic              r_err;
    logic [15:0]       r_pkt_count;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_rd_idx;
    logic [ADDR_W-1:0] r_addr;
    logic              r_infl;
    logic              r_infl_last;

    stream_beat_t      w_head;
    stream_beat_t      w_push_beat;
    logic              w_valid;
    logic              w_pop;
    logic [1:0]        w_fifo_count;
    logic [2:0]        w_occ;
    logic              w_issue;
    logic              w_issue_last;
    logic [LEN_W-1:0]  w_len_clip;

    // A byte popped this cycle frees its slot in time for the read issued
    // now, which is what sustains one byte per cycle with a 2-entry FIFO.
    assign w_occ        = {1'b0, w_fifo_count} + {2'b00, r_infl} - {2'b00, w_pop};
    assign w_issue      = (r_state == ST_READ) && (w_occ < 3'd2);
    assign w_issue_last = (r_rd_idx == (r_len - LEN_W'(1)));
    assign w_len_clip   = (buf_out_len > LP_MAX_LEN) ? LP_MAX_LEN : buf_out_len;
    assign w_push_beat  = '{last: r_infl_last, data: buf_out_q};

    // The read port samples the address in the issue cycle; between reads
    // the last issued address is held.
    assign buf_out_addr   = w_issue ? r_rd_idx[ADDR_W-1:0] : r_addr;
    assign buf_out_arm    = r_arm;
    assign zlp_pulse      = r_zlp;
    assign err_len        = r_err;
    assign stat_pkt_count = r_pkt_count;
    assign m_data         = w_head.data;
    assign m_last         = w_head.last;
    assign m_valid        = w_valid;

    usb_skid_fifo u_fifo (
        .i_clk   (clk_125),
        .i_rst   (reset),
        .i_push  (r_infl),
        .i_din   (w_push_beat),
        .i_ready (m_ready),
        .o_dout  (w_head),
        .o_valid (w_valid),
        .o_pop   (w_pop),
        .o_count (w_fifo_count)
    );

    // Sequencing FSM with read issue tracking and registered status outputs.
    always_ff @(posedge clk_125 or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_arm       <= 1'b0;
            r_zlp       <= 1'b0;
            r_err       <= 1'b0;
            r_pkt_count <= 16'd0;
            r_len       <= '0;
            r_rd_idx    <= '0;
            r_addr      <= '0;
            r_infl      <= 1'b0;
            r_infl_last <= 1'b0;
        end else begin
            r_zlp  <= 1'b0;
            r_infl <= w_issue;
            if (w_issue) begin
                r_infl_last <= w_issue_last;
                r_addr      <= r_rd_idx[ADDR_W-1:0];
                r_rd_idx    <= r_rd_idx + LEN_W'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state <= ST_ARM;
                        r_arm   <= 1'b1;
                    end
                end
                ST_ARM: begin
                    if (buf_out_arm_ack) begin
                        r_state <= ST_WAIT_DATA;
                        r_arm   <= 1'b0;
                    end
                end
                ST_WAIT_DATA: begin
                    if (buf_out_hasdata) begin
                        r_len <= w_len_clip;
                        if (buf_out_len > LP_MAX_LEN) begin
                            r_err <= 1'b1;
                        end
                        if (w_len_clip == '0) begin
                            r_zlp       <= 1'b1;
                            r_pkt_count <= r_pkt_count + 16'd1;
                            if (enable) begin
                                r_state <= ST_ARM;
                                r_arm   <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_rd_idx <= '0;
                            r_state  <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (w_issue && w_issue_last) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && w_head.last) begin
                        r_pkt_count <= r_pkt_count + 16'd1;
                        if (enable) begin
                            r_state <= ST_ARM;
                            r_arm   <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_arm   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_buf_out_reader.sv
// Bench for usb_buf_out_reader: a behavioural buffer core (sync-read RAM,
// arm/ack, hasdata) plus a packet-level reference of what the stream must carry.
module tb_usb_buf_out_reader;

    logic        clk_125;
    logic        reset;
    logic        enable;
    logic [8:0]  buf_out_addr;
    logic [7:0]  buf_out_q;
    logic [9:0]  buf_out_len;
    logic        buf_out_hasdata;
    logic        buf_out_arm;
    logic        buf_out_arm_ack;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;
    logic        zlp_pulse;
    logic        err_len;
    logic [15:0] stat_pkt_count;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;
    bit exp_err = 1'b0;

    logic [7:0] mem [512];

    usb_buf_out_reader dut (
        .clk_125         (clk_125),
        .reset           (reset),
        .enable          (enable),
        .buf_out_addr    (buf_out_addr),
        .buf_out_q       (buf_out_q),
        .buf_out_len     (buf_out_len),
        .buf_out_hasdata (buf_out_hasdata),
        .buf_out_arm     (buf_out_arm),
        .buf_out_arm_ack (buf_out_arm_ack),
        .m_data          (m_data),
        .m_valid         (m_valid),
        .m_last          (m_last),
        .m_ready         (m_ready),
        .zlp_pulse       (zlp_pulse),
        .err_len         (err_len),
        .stat_pkt_count  (stat_pkt_count)
    );

    initial clk_125 = 1'b0;
    always #4 clk_125 = ~clk_125;

    // Buffer read port: data valid one cycle after the address.
    always @(posedge clk_125) buf_out_q <= mem[buf_out_addr];

    task automatic tick();
        @(negedge clk_125);
    endtask

    // Waits for an arm request, acks it after ack_after high cycles, reports
    // how many cycles the request stayed high.
    task automatic arm_handshake(input int ack_after, output int arm_cycles);
        int t;
        t = 0;
        arm_cycles = 0;
        while (!buf_out_arm && t < 50) begin
            tick();
            t++;
        end
        checks++;
        if (buf_out_arm !== 1'b1) begin
            errors++;
            $display("FAIL arm_request: buf_out_arm=%b expected 1 within 50 cycles", buf_out_arm);
        end
        while (buf_out_arm && arm_cycles < 50) begin
            arm_cycles++;
            if (arm_cycles == ack_after) buf_out_arm_ack = 1'b1;
            tick();
            if (buf_out_arm_ack) begin
                buf_out_arm_ack = 1'b0;
                buf_out_hasdata = 1'b0;
            end
        end
    endtask

    // Presents one packet of len bytes from mem and checks the stream against
    // the expected byte sequence. drop_at/abort_at act when that many bytes
    // have been accepted (-1 disables).
    task automatic run_packet(input int len, input int ready_pct, input int drop_at,
                              input int abort_at, input string name);
        logic [7:0] exp_q[$];
        int elen;
        int got;
        int cyc;
        bit ahead_bad;
        int worst_addr;
        bit aborted;
        elen = (len > 512) ? 512 : len;
        for (int i = 0; i < elen; i++) exp_q.push_back(mem[i]);
        got = 0;
        cyc = 0;
        ahead_bad = 1'b0;
        worst_addr = 0;
        aborted = 1'b0;
        buf_out_len = 10'(len);
        buf_out_hasdata = 1'b1;
        while (got < elen && cyc < elen * 20 + 50 && !aborted) begin
            tick();
            cyc++;
            m_ready = ($urandom_range(99) < ready_pct);
            if (got == drop_at) enable = 1'b0;
            #1;
            if (got >= 1 && int'(buf_out_addr) > got + 2) begin
                ahead_bad = 1'b1;
                worst_addr = int'(buf_out_addr);
            end
            if (m_valid && m_ready) begin
                checks++;
                if (m_data !== exp_q[got] || m_last !== (got == elen - 1)) begin
                    errors++;
                    $display("FAIL %s byte%0d: data=%02h last=%b expected data=%02h last=%b",
                             name, got, m_data, m_last, exp_q[got], (got == elen - 1));
                end
                got++;
                if (got == abort_at) aborted = 1'b1;
            end
        end
        if (aborted) return;
        checks++;
        if (got != elen) begin
            errors++;
            $display("FAIL %s length: accepted %0d bytes expected %0d", name, got, elen);
        end
        checks++;
        if (ahead_bad) begin
            errors++;
            $display("FAIL %s addr_ahead: addr %0d more than 2 ahead of accepted count", name, worst_addr);
        end
        m_ready = 1'b1;
        tick();
        exp_count = (exp_count + 1) & 16'hFFFF;
        if (len > 512) exp_err = 1'b1;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s extra_byte: m_valid=%b expected 0 after last", name, m_valid);
        end
        checks++;
        if (stat_pkt_count !== 16'(exp_count)) begin
            errors++;
            $display("FAIL %s count: %0d expected %0d", name, stat_pkt_count, exp_count);
        end
        checks++;
        if (err_len !== exp_err) begin
            errors++;
            $display("FAIL %s err_len: %b expected %b", name, err_len, exp_err);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({buf_out_arm, m_valid, m_data, m_last, zlp_pulse, err_len, stat_pkt_count, buf_out_addr} !== '0) begin
            errors++;
            $display("FAIL %s outputs: arm=%b valid=%b data=%02h last=%b zlp=%b err=%b count=%0d addr=%0d expected all 0",
                     name, buf_out_arm, m_valid, m_data, m_last, zlp_pulse, err_len, stat_pkt_count, buf_out_addr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        buf_out_len = '0;
        buf_out_hasdata = 1'b0;
        buf_out_arm_ack = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        #1;
        check_all_zero("reset");
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_all_zero("post_reset_idle");
    endtask

    task automatic test_arm_handshake();
        int n;
        enable = 1'b1;
        arm_handshake(3, n);
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL arm_cycles: arm high %0d cycles expected 3", n);
        end
        tick();
        checks++;
        if (buf_out_arm !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL arm_wait: arm=%b valid=%b expected 0 0", buf_out_arm, m_valid);
        end
    endtask

    task automatic test_four_byte();
        logic [7:0] seen [7];
        logic       seen_v [7];
        logic       seen_l [7];
        int n;
        for (int i = 0; i < 4; i++) mem[i] = 8'hA0 + 8'(i);
        m_ready = 1'b1;
        buf_out_len = 10'd4;
        buf_out_hasdata = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            seen[k] = m_data;
            seen_v[k] = m_valid;
            seen_l[k] = m_last;
        end
        for (int k = 1; k <= 6; k++) begin
            checks++;
            if (k < 3) begin
                if (seen_v[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL four_byte early_valid t0+%0d: valid=%b expected 0", k, seen_v[k]);
                end
            end else if (seen_v[k] !== 1'b1 || seen[k] !== 8'hA0 + 8'(k - 3) || seen_l[k] !== (k == 6)) begin
                errors++;
                $display("FAIL four_byte t0+%0d: valid=%b data=%02h last=%b expected 1 %02h %b",
                         k, seen_v[k], seen[k], seen_l[k], 8'hA0 + 8'(k - 3), (k == 6));
            end
        end
        tick();
        exp_count++;
        checks++;
        if (stat_pkt_count !== 16'(exp_count) || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL four_byte done: count=%0d valid=%b expected %0d 0", stat_pkt_count, m_valid, exp_count);
        end
        arm_handshake(1, n);
    endtask

    task automatic test_backpressure();
        int n;
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
        run_packet(64, 50, -1, -1, "backpressure");
        arm_handshake(2, n);
    endtask

    task automatic test_zlp();
        int zl;
        int vl;
        int n;
        zl = 0;
        vl = 0;
        m_ready = 1'b1;
        buf_out_len = 10'd0;
        buf_out_hasdata = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (zlp_pulse) zl++;
            if (m_valid) vl++;
        end
        exp_count++;
        checks++;
        if (zl != 1) begin
            errors++;
            $display("FAIL zlp_pulse: high %0d cycles expected 1", zl);
        end
        checks++;
        if (vl != 0) begin
            errors++;
            $display("FAIL zlp_valid: m_valid high %0d cycles expected 0", vl);
        end
        checks++;
        if (stat_pkt_count !== 16'(exp_count)) begin
            errors++;
            $display("FAIL zlp_count: %0d expected %0d", stat_pkt_count, exp_count);
        end
        arm_handshake(1, n);
    endtask

    task automatic test_oversize();
        int n;
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        run_packet(600, 75, -1, -1, "oversize");
        arm_handshake(1, n);
    endtask

    task automatic test_back_to_back();
        int n;
        int len;
        for (int p = 0; p < 6; p++) begin
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) mem[i] = 8'($urandom);
            run_packet(len, $urandom_range(30, 100), -1, -1, "random_pkt");
            arm_handshake($urandom_range(1, 4), n);
        end
    endtask

    task automatic test_enable_drop();
        int armed;
        int n;
        for (int i = 0; i < 20; i++) mem[i] = 8'($urandom);
        run_packet(20, 100, 5, -1, "enable_drop");
        armed = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (buf_out_arm) armed++;
        end
        checks++;
        if (armed != 0) begin
            errors++;
            $display("FAIL enable_drop rearm: arm high %0d cycles expected 0", armed);
        end
        enable = 1'b1;
        arm_handshake(1, n);
    endtask

    task automatic test_reset_mid_packet();
        int n;
        for (int i = 0; i < 100; i++) mem[i] = 8'($urandom);
        run_packet(100, 100, -1, 10, "reset_mid");
        #1 reset = 1'b1;
        #1;
        check_all_zero("reset_mid_packet");
        exp_count = 0;
        exp_err = 1'b0;
        tick();
        reset = 1'b0;
        arm_handshake(2, n);
        checks++;
        if (stat_pkt_count !== 16'd0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rearm: count=%0d valid=%b expected 0 0", stat_pkt_count, m_valid);
        end
        for (int i = 0; i < 5; i++) mem[i] = 8'($urandom);
        run_packet(5, 100, -1, -1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_arm_handshake();
        test_four_byte();
        test_backpressure();
        test_zlp();
        test_oversize();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
